// File: rtl/i2s_stream_sched_pkg.sv
// Shared constants and types for the I2S stream scheduler.
// Build option: I2S_MUTE_ON_UNDERRUN_EN (see i2s_stream_sched).
package i2s_pkg;

    localparam int SAMPLE_W_DEF = 24;
    localparam int OUT_W_DEF    = 16;
    localparam int CNT_W_DEF    = 16;

    localparam logic [7:0] CAP_PHASE = 8'd229;
    localparam logic [7:0] TXL_PHASE = 8'd255;

    localparam int BCK_BIT  = 1;
    localparam int LRCK_BIT = 7;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        WAIT_RES
    } sched_state_t;

endpackage

// File: rtl/i2s_stream_sched_clkgen.sv
// Free-running 8-bit prescaler producing the I2S clocks and the
// per-frame capture/transmit phase strobes.
module i2s_clkgen
    import i2s_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic scki,
    output logic bck,
    output logic lrck,
    output logic cap,
    output logic txl
);

    logic [7:0] prescaler;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prescaler <= '0;
        else       prescaler <= prescaler + 8'd1;
    end

    assign scki = clk;
    assign bck  = prescaler[BCK_BIT];
    assign lrck = prescaler[LRCK_BIT];
    assign cap  = (prescaler == CAP_PHASE);
    assign txl  = (prescaler == TXL_PHASE);

endmodule

// File: rtl/i2s_stream_sched.sv
// Frame sequencer: captures rx samples, hands them to the filter, loads results
// into tx at the frame boundary. Define I2S_MUTE_ON_UNDERRUN_EN to mute on underrun.
module i2s_stream_sched
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clr_flags,
    output logic                scki,
    output logic                bck,
    output logic                lrck,
    input  logic [SAMPLE_W-1:0] rx_left,
    input  logic [SAMPLE_W-1:0] rx_right,
    output logic                proc_valid,
    input  logic                proc_ready,
    output logic [SAMPLE_W-1:0] proc_left,
    output logic [SAMPLE_W-1:0] proc_right,
    input  logic                res_valid,
    output logic                res_ready,
    input  logic [OUT_W-1:0]    res_left,
    input  logic [OUT_W-1:0]    res_right,
    output logic [OUT_W-1:0]    tx_left,
    output logic [OUT_W-1:0]    tx_right,
    output logic                tx_load,
    output logic                overrun,
    output logic                underrun,
    output logic [CNT_W-1:0]    frame_cnt
);

    logic cap, txl;

    i2s_clkgen u_clkgen (
        .clk   (clk),
        .reset (reset),
        .scki  (scki),
        .bck   (bck),
        .lrck  (lrck),
        .cap   (cap),
        .txl   (txl)
    );

    sched_state_t state, state_nxt;
    logic [OUT_W-1:0] hold_left, hold_right;
    logic pending;
    logic res_acc, cap_take, ov_ev, un_ev;

    // Valids come straight from state so neither depends on the peer's ready.
    assign proc_valid = (state == OFFER);
    assign res_ready  = (state == WAIT_RES);
    assign res_acc    = res_valid && res_ready;

    // A CAP landing on an accepted sample is dropped rather than overwriting it.
    assign cap_take = enable && cap &&
                      ((state == IDLE) || (state == OFFER && !proc_ready));
    assign ov_ev    = enable && ((cap && state != IDLE) || (res_acc && pending));
    assign un_ev    = enable && txl && !res_acc && !pending;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cap)        state_nxt = OFFER;
            OFFER:    if (proc_ready) state_nxt = WAIT_RES;
            WAIT_RES: if (res_valid)  state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
        if (!enable) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proc_left  <= '0;
            proc_right <= '0;
            hold_left  <= '0;
            hold_right <= '0;
            pending    <= 1'b0;
            tx_left    <= '0;
            tx_right   <= '0;
            tx_load    <= 1'b0;
            frame_cnt  <= '0;
            overrun    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            tx_load <= txl;
            if (txl) frame_cnt <= frame_cnt + 1'b1;

            if (cap_take) begin
                proc_left  <= rx_left;
                proc_right <= rx_right;
            end

            // TXL always consumes the hold slot; a same-cycle result bypasses it.
            if (!enable || txl) begin
                pending <= 1'b0;
            end else if (res_acc) begin
                hold_left  <= res_left;
                hold_right <= res_right;
                pending    <= 1'b1;
            end

            if (txl) begin
                if (!enable) begin
                    tx_left  <= '0;
                    tx_right <= '0;
                end else if (res_acc) begin
                    tx_left  <= res_left;
                    tx_right <= res_right;
                end else if (pending) begin
                    tx_left  <= hold_left;
                    tx_right <= hold_right;
                end
`ifdef I2S_MUTE_ON_UNDERRUN_EN
                else begin
                    tx_left  <= '0;
                    tx_right <= '0;
                end
`endif
            end

            if (ov_ev)          overrun <= 1'b1;
            else if (clr_flags) overrun <= 1'b0;

            if (un_ev)          underrun <= 1'b1;
            else if (clr_flags) underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_stream_sched.sv
// Directed bench for i2s_stream_sched: frame timing, handshakes, flags, enable, reset.
module tb_i2s_stream_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        clr_flags = 1'b0;
    logic        scki, bck, lrck;
    logic [23:0] rx_left = '0, rx_right = '0;
    logic        proc_valid;
    logic        proc_ready = 1'b1;
    logic [23:0] proc_left, proc_right;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [15:0] res_left = '0, res_right = '0;
    logic [15:0] tx_left, tx_right;
    logic        tx_load, overrun, underrun;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] ph;
    logic [15:0] exp_hold;

    i2s_stream_sched dut (
        .clk(clk), .reset(reset), .enable(enable), .clr_flags(clr_flags),
        .scki(scki), .bck(bck), .lrck(lrck),
        .rx_left(rx_left), .rx_right(rx_right),
        .proc_valid(proc_valid), .proc_ready(proc_ready),
        .proc_left(proc_left), .proc_right(proc_right),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_left(res_left), .res_right(res_right),
        .tx_left(tx_left), .tx_right(tx_right), .tx_load(tx_load),
        .overrun(overrun), .underrun(underrun), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Bench's own frame-phase reference: counts clk edges since reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) ph <= '0;
        else       ph <= ph + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ph(input logic [7:0] p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ph != p && n < 300);
        checks++;
        assert (ph == p) else begin
            errors++;
            $error("FAIL wait_ph: observed phase %0d expected %0d", ph, p);
        end
    endtask

    initial begin
`ifdef I2S_MUTE_ON_UNDERRUN_EN
        exp_hold = 16'h0000;
`else
        exp_hold = 16'hABCD;
`endif
        rx_left  = 24'h123456;
        rx_right = 24'h654321;
        #12;
        chk("rst_proc_valid", proc_valid, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_tx_left", tx_left, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_flags", {overrun, underrun}, 0);
        @(negedge clk) reset = 1'b0;

        // Frame 1: clocks and normal flow
        wait_ph(8'd1);   chk("bck_p1", bck, 0);
        wait_ph(8'd2);   chk("bck_p2", bck, 1);
        wait_ph(8'd4);   chk("bck_p4", bck, 0);
        wait_ph(8'd127); chk("lrck_p127", lrck, 0);
        wait_ph(8'd128); chk("lrck_p128", lrck, 1);
        wait_ph(8'd229); chk("pv_p229", proc_valid, 0);
        wait_ph(8'd230);
        chk("pv_p230", proc_valid, 1);
        chk("proc_left_f1", proc_left, 24'h123456);
        chk("proc_right_f1", proc_right, 24'h654321);
        wait_ph(8'd231); chk("rr_p231", res_ready, 1);
        wait_ph(8'd240);
        res_valid = 1'b1; res_left = 16'hABCD; res_right = 16'h1234;
        wait_ph(8'd241);
        res_valid = 1'b0;
        chk("rr_after_acc", res_ready, 0);
        wait_ph(8'd0);
        chk("tx_left_f1", tx_left, 16'hABCD);
        chk("tx_right_f1", tx_right, 16'h1234);
        chk("tx_load_f1", tx_load, 1);
        chk("frame_cnt_f1", frame_cnt, 1);
        chk("flags_f1", {overrun, underrun}, 2'b00);
        proc_ready = 1'b0;
        rx_left = 24'h111111;
        wait_ph(8'd1);   chk("tx_load_pulse", tx_load, 0);

        // Frames 2-3: filter stalls, second capture overwrites
        wait_ph(8'd230); chk("proc_left_f2", proc_left, 24'h111111);
        wait_ph(8'd100);
        rx_left = 24'h222222;
        wait_ph(8'd230);
        chk("proc_left_f3", proc_left, 24'h222222);
        chk("pv_f3", proc_valid, 1);
        chk("overrun_set", overrun, 1);
        chk("underrun_f2", underrun, 1);
        clr_flags = 1'b1;
        wait_ph(8'd231);
        clr_flags = 1'b0;
        chk("flags_cleared", {overrun, underrun}, 2'b00);
        proc_ready = 1'b1;
        wait_ph(8'd232); chk("rr_f3", res_ready, 1);

        // Filter never responds -> underrun
        wait_ph(8'd0);
        chk("underrun_f3", underrun, 1);
        chk("tx_left_underrun", tx_left, exp_hold);
        chk("tx_load_f3", tx_load, 1);
        chk("frame_cnt_f3", frame_cnt, 3);
        clr_flags = 1'b1;
        wait_ph(8'd1);
        clr_flags = 1'b0;
        chk("underrun_cleared", underrun, 0);

        // Frame 4: capture dropped while waiting, result accepted at phase 255
        wait_ph(8'd230);
        chk("overrun_drop", overrun, 1);
        chk("pv_drop", proc_valid, 0);
        wait_ph(8'd255);
        res_valid = 1'b1; res_left = 16'h5A5A; res_right = 16'hA5A5;
        wait_ph(8'd0);
        res_valid = 1'b0;
        chk("tx_left_bypass", tx_left, 16'h5A5A);
        chk("tx_right_bypass", tx_right, 16'hA5A5);
        chk("tx_load_bypass", tx_load, 1);
        chk("underrun_bypass", underrun, 0);
        chk("pending_bypass", dut.pending, 0);
        chk("frame_cnt_f4", frame_cnt, 4);

        // Frame 5: enable dropped in WAIT_RES
        rx_left = 24'h333333;
        wait_ph(8'd230); chk("proc_left_f5", proc_left, 24'h333333);
        wait_ph(8'd231);
        chk("rr_f5", res_ready, 1);
        enable = 1'b0;
        wait_ph(8'd232);
        chk("pv_disabled", proc_valid, 0);
        chk("rr_disabled", res_ready, 0);
        wait_ph(8'd0);
        chk("tx_left_disabled", tx_left, 0);
        chk("tx_right_disabled", tx_right, 0);
        chk("tx_load_disabled", tx_load, 1);
        chk("underrun_disabled", underrun, 0);
        chk("frame_cnt_f5", frame_cnt, 5);

        // Mid-frame asynchronous reset
        enable = 1'b1;
        wait_ph(8'd102);
        chk("bck_p102", bck, 1);
        #2 reset = 1'b1;
        #1;
        chk("mrst_bck", bck, 0);
        chk("mrst_lrck", lrck, 0);
        chk("mrst_proc_left", proc_left, 0);
        chk("mrst_frame_cnt", frame_cnt, 0);
        chk("mrst_overrun", overrun, 0);
        chk("mrst_tx_load", tx_load, 0);
        @(negedge clk) reset = 1'b0;
        wait_ph(8'd2);   chk("mrst_bck_p2", bck, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_stream_sched.md
Name: i2s_stream_sched

Overview:
- Central timing and sequencing controller for the audio path.
- Generates the shared I2S clocks (scki, bck, lrck) used by both the PCM1808 capture receiver and the I2S transmitter.
- Once per frame, latches the receiver's left/right sample and offers it to the downstream filter over a valid/ready handshake.
- Accepts the filtered result over a second valid/ready handshake and loads it into the transmitter holding registers at the frame boundary.
- Reports overrun/underrun through sticky flags.

Parameters:
- SAMPLE_W, 24, width of captured samples offered to the filter.
- OUT_W, 16, width of filtered results and transmitter data.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  system clock, 12 MHz.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  stream enable; prescaler runs regardless.
- clr_flags  in  1  synchronous clear of overrun/underrun.
- scki  out  1  PCM1808 system clock, equals clk.
- bck  out  1  bit clock, prescaler[1], clk/4.
- lrck  out  1  left/right clock, prescaler[7], clk/256 (Fs = 46.875 kHz).
- rx_left, rx_right  in  SAMPLE_W  receiver output registers.
- proc_valid  out  1  captured sample available.
- proc_ready  in  1  filter accepts sample.
- proc_left, proc_right  out  SAMPLE_W  captured sample.
- res_valid  in  1  filter result available.
- res_ready  out  1  controller accepts result.
- res_left, res_right  in  OUT_W  filter result.
- tx_left, tx_right  out  OUT_W  transmitter holding registers.
- tx_load  out  1  one-cycle pulse: tx registers just updated.
- overrun  out  1  sticky: sample or result dropped or overwritten.
- underrun  out  1  sticky: no fresh result at frame boundary.
- frame_cnt  out  CNT_W  frames transmitted, wraps.

Behaviour:
- Reset (async, active-high) clears to 0: the 8-bit free-running prescaler, bck, lrck, proc_valid, res_ready, proc_*, tx_*, tx_load, overrun, underrun, frame_cnt, pending. State = IDLE.
- Phase strobes are decoded from the prescaler:
  - CAP when prescaler==229. This is the cycle after the receiver updates left/right at 228.
  - TXL when prescaler==255.
- State machine, sample side:
  - IDLE: on CAP with enable=1, latch rx_left/rx_right into proc_*, then go to OFFER. proc_valid is high from the next cycle (prescaler==230).
  - OFFER: proc_valid=1. On proc_valid&&proc_ready, go to WAIT_RES; res_ready=1 from the next cycle.
  - WAIT_RES: res_ready=1. On res_valid&&res_ready, capture res_* into the hold registers, set pending=1, go to IDLE.
- CAP arriving in OFFER: overwrite proc_* with the new sample, stay in OFFER, set overrun.
- CAP arriving in WAIT_RES: drop the new sample, set overrun.
- Result accepted while pending=1 already: overwrite the hold registers, set overrun.
- On TXL:
  - If pending=1: tx_* <= hold, pending <= 0.
  - If a result is accepted in the same cycle: bypass, so tx_* <= res_* and pending stays 0.
  - Otherwise: set underrun; tx_* keep their value (see Optional Feature).
  - In all cases: tx_load=1 in the following cycle (prescaler==0, start of the left slot), and frame_cnt increments, wrapping at 2^CNT_W.
- enable=0:
  - State returns to IDLE next cycle; proc_valid and res_ready deassert.
  - CAP is ignored; pending is cleared.
  - At TXL, tx_* load 0 and no underrun is flagged; tx_load and frame_cnt continue.
- clr_flags clears both flags. A flag event in the same cycle wins: the flag stays set.
- Handshake rules: proc_* are stable while proc_valid=1 and not accepted, except for the overrun overwrite. Neither valid output depends combinationally on the peer's ready.

Optional Feature:
- Macro I2S_MUTE_ON_UNDERRUN_EN.
- Defined: on TXL underrun, tx_* load 0 (mute).
- Undefined: tx_* repeat the last transmitted value.
- Underrun flagging is identical in both builds.

Decomposition:
- Package i2s_pkg holds:
  - SAMPLE_W and OUT_W defaults.
  - CAP_PHASE=8'd229 and TXL_PHASE=8'd255.
  - BCK_BIT=1 and LRCK_BIT=7.
  - sched_state_t enum {IDLE, OFFER, WAIT_RES}.
- One sub-module, i2s_clkgen: prescaler, scki/bck/lrck, and the CAP/TXL strobes.

Test Plan:
- Reset mid-frame (prescaler≈100): all outputs 0 immediately. After release, bck toggles every 2 clk and lrck every 128 clk; first CAP occurs 229 cycles after release.
- Normal flow: rx_left=24'h123456, proc_ready tied 1, filter returns res_left=16'hABCD 10 cycles later. Required: proc_left=24'h123456 at prescaler 230; tx_left=16'hABCD with tx_load high at prescaler 0; frame_cnt=1; no flags.
- proc_ready held 0 across two frames: proc_left tracks the second sample and overrun=1. clr_flags then gives overrun=0.
- Filter never responds: at TXL, underrun=1. tx_left holds the previous value, or 0 with I2S_MUTE_ON_UNDERRUN_EN.
- res_valid accepted at exactly prescaler 255: tx_left takes the new result at prescaler 0, pending=0, no underrun.
- enable dropped while in WAIT_RES: proc_valid=0 and res_ready=0 next cycle. At TXL, tx_*=0, tx_load pulses, underrun stays 0.
